cic_decimator: RTL and testbench
================================

# cic_decimator

Third-order CIC decimating low-pass filter between the SID voice output and the I2S master. Integrates the signed 16-bit SID sample on every 1 MHz `TICK` gate, decimates by 2^DECIM_LOG2 and runs the comb section serially over three `CLK` cycles with one shared subtractor. Emits a gain-normalised signed 16-bit sample with a one-cycle `VALID` strobe. Its purpose is to remove content above the audio band before the I2S stage resamples it.

## Interface
- `DECIM_LOG2`, default 4: log2 of the decimation ratio R; legal range 2..6. The default gives R=16 and 62.5 kHz out of 1 MHz.
- `CLK` input 1: system clock, 12 MHz or 48 MHz build.
- `RST` input 1: synchronous, active-high reset.
- `TICK` input 1: one-`CLK`-wide input-sample gate (the SID 1 MHz gate).
- `IN` input 16: signed two's-complement input sample, valid on `TICK` cycles.
- `OUT` output 16: signed filtered sample, held between updates.
- `VALID` output 1: one-`CLK` pulse when `OUT` takes a new value.

## Operation
- Internal width W = 16 + 3*DECIM_LOG2 (28 at default). All integrator and comb registers are W bits, and all arithmetic is modular two's complement. Integrator wrap-around is intentional and must not be saturated.
- `IN` is sign-extended to W bits.
- Integrators update only on `TICK` cycles, pipelined on old values: I1 <= I1+IN, I2 <= I2+I1, I3 <= I3+I2.
- Decimation counter `cnt`, DECIM_LOG2 bits, increments on each `TICK` and wraps from R-1 to 0.
- A `TICK` with cnt==R-1 is a boundary. FSM states: IDLE, C1, C2, C3.
  - IDLE: on boundary go to C1; otherwise stay in IDLE.
  - C1: Y <= I3 - D1, D1 <= I3. I3 here already includes the boundary tick. Go to C2.
  - C2: Y <= Y - D2, D2 <= Y. Go to C3.
  - C3: Z = Y - D3, D3 <= Y. `OUT` <= scaled(Z), `VALID` <= 1. Go to IDLE.
- `TICK` during C1..C3 updates the integrators normally. A boundary cannot occur during C1..C3 because R>=4 ticks separate boundaries and ticks are at least 1 `CLK` apart.
- scaled(Z) = Z arithmetically shifted right by 3*DECIM_LOG2, keeping the low 16 bits. DC gain is exactly 1, so the result fits in 16 bits without rounding.
- Reset: I1..I3, D1..D3, Y, `cnt` = 0; state = IDLE; `OUT` = 16'h0000; `VALID` = 0. Reset wins over `TICK` in the same cycle. Reset during C1..C3 aborts the sequence, and no `VALID` is issued.

## Timing
- Boundary `TICK` in cycle t: C1 in t+1, C2 in t+2, C3 in t+3. `VALID` is high and the new `OUT` is visible in cycle t+4. Latency is therefore 4 `CLK` cycles from the boundary tick.
- `VALID` is high for exactly one cycle per R ticks. It is never asserted in two consecutive cycles.
- Step response settles after 3 output periods: the 3rd `VALID` after a DC step carries the final value.
- First `VALID` after reset follows the R-th `TICK`.

## Configuration
- `CIC_ROUND_EN` defined:
  - Adds 2^(3*DECIM_LOG2-1) to Z before the shift, giving round-half-up.
  - Clamps positive overflow to 16'h7FFF. Negative results cannot overflow.
- `CIC_ROUND_EN` undefined:
  - Pure arithmetic-shift truncation (floor), with no adder and no clamp.

## Test plan
- DC: reset, then `IN`=16'h1000 on every `TICK` (spacing 48 `CLK`). Required: from the 3rd `VALID` onward, `OUT`=16'h1000; `VALID` every 16 ticks, exactly 4 `CLK` after the boundary tick.
- Extremes and integrator wrap: 20000 ticks at `IN`=16'h7FFF. Required: settled `OUT`=16'h7FFF throughout, with no glitch when the integrators wrap. Then `IN`=16'h8000 for 64 ticks; required: settled `OUT`=16'h8000.
- Nyquist rejection: `IN` alternating +16'h4000 and -16'h4000 per tick. Required: settled `OUT` within {16'hFFFF, 16'h0000} in truncation mode, and 16'h0000 with `CIC_ROUND_EN`.
- Back-to-back ticks: `TICK` high every `CLK` for 64 cycles with DC 16'h0100. Required: `VALID` every 16 cycles, `OUT`=16'h0100 once settled, and the FSM is never re-triggered mid-sequence.
- Reset mid-comb: assert `RST` in the C2 cycle. Required: no `VALID`, `OUT`=16'h0000 on the next cycle, and the first `VALID` after release follows the 16th subsequent `TICK`.
- Rounding, `CIC_ROUND_EN` only: DC `IN`=16'h7FFF. Required: `OUT`=16'h7FFF, with no wrap to 16'h8000.

Source files
------------

// File: rtl/cic_decimator.sv
// cic_decimator: 3rd-order CIC low-pass, decimate by 2^DECIM_LOG2, serial comb on one shared subtractor.
// Define CIC_ROUND_EN for round-half-up output with positive clamp; default is floor truncation.
module cic_decimator #(
  parameter int DECIM_LOG2 = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        TICK,
  input  logic [15:0] IN,
  output logic [15:0] OUT,
  output logic        VALID
);
  localparam int S = 3 * DECIM_LOG2;
  localparam int W = 16 + S;
  typedef enum logic [1:0] {IDLE, C1, C2, C3} state_t;
  state_t state_q;
  logic signed [W-1:0] i1_q, i2_q, i3_q, d1_q, d2_q, d3_q, y_q;
  logic signed [W-1:0] x, sub_a, sub_b, z;
  logic [DECIM_LOG2-1:0] cnt_q;
  logic [15:0] out_d;
  assign x = {{S{IN[15]}}, IN};
  always_comb begin
    sub_a = state_q == C1 ? i3_q : y_q;
    sub_b = state_q == C1 ? d1_q : state_q == C2 ? d2_q : d3_q;
    z = sub_a - sub_b;
  end
`ifdef CIC_ROUND_EN
  localparam logic signed [W-1:0] HALF = W'(1) << (S - 1);
  logic signed [W-1:0] zr;
  // a sign flip caused by the rounding add can only be positive overflow
  always_comb begin
    zr = z + HALF;
    out_d = (!z[W-1] && zr[W-1]) ? 16'h7FFF : 16'(zr >>> S);
  end
`else
  always_comb out_d = 16'(z >>> S);
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      i1_q <= '0;
      i2_q <= '0;
      i3_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      d3_q <= '0;
      y_q <= '0;
      cnt_q <= '0;
      state_q <= IDLE;
      OUT <= 16'h0000;
      VALID <= 1'b0;
    end else begin
      VALID <= 1'b0;
      if (TICK) begin
        i1_q <= i1_q + x;
        i2_q <= i2_q + i1_q;
        i3_q <= i3_q + i2_q;
        cnt_q <= cnt_q + DECIM_LOG2'(1);
      end
      case (state_q)
        IDLE: if (TICK && &cnt_q) state_q <= C1;
        C1: begin
          y_q <= z;
          d1_q <= i3_q;
          state_q <= C2;
        end
        C2: begin
          y_q <= z;
          d2_q <= y_q;
          state_q <= C3;
        end
        default: begin
          d3_q <= y_q;
          OUT <= out_d;
          VALID <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: scoreboard bench; stimulus queues hand-computed outputs, a negedge monitor checks them.
module tb_cic_decimator;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic TICK = 1'b0;
  logic [15:0] IN = 16'h0000;
  logic [15:0] OUT;
  logic VALID;
  cic_decimator #(.DECIM_LOG2(4)) dut (
    .CLK(CLK), .RST(RST), .TICK(TICK), .IN(IN), .OUT(OUT), .VALID(VALID)
  );
  always #5 CLK = ~CLK;
  // kind: 0 exact, 1 Nyquist tolerance {FFFF,0000}, 2 value not checked
  typedef struct {
    int cyc;
    logic [15:0] val;
    int kind;
  } exp_t;
  exp_t sb[$];
  exp_t m_e;
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int tcnt = 0;
  logic prev_v = 1'b0;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  always @(negedge CLK) begin
    if (VALID === 1'b1) begin
      checks++;
      if (prev_v) begin
        fails++;
        $display("FAIL valid_consecutive: VALID high two cycles at cycle %0d", cyc);
      end
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_valid: got VALID at cycle %0d out=%h expected none", cyc, OUT);
      end else begin
        m_e = sb.pop_front();
        checks++;
        if (cyc != m_e.cyc) begin
          fails++;
          $display("FAIL valid_latency: got cycle %0d expected %0d", cyc, m_e.cyc);
        end
        if (m_e.kind == 0) chk("out_value", OUT, m_e.val);
        else if (m_e.kind == 1) begin
          checks++;
          if (OUT !== 16'h0000 && OUT !== 16'hFFFF) begin
            fails++;
            $display("FAIL nyquist_out: got %h expected 0000 or ffff", OUT);
          end
        end
      end
    end
    prev_v = VALID;
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic do_reset();
    RST = 1'b1;
    TICK = 1'b0;
    idle(2);
    chk("reset_out", OUT, 16'h0000);
    chk("reset_valid", {15'b0, VALID}, 16'h0000);
    RST = 1'b0;
    tcnt = 0;
  endtask
  // n ticks spaced gap cycles; outputs 0 and 1 after start use e0/e1 (kind k01), later ones es (kind ks)
  task automatic run(input logic [15:0] a, input logic alt, input int n, input int gap,
                     input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] es,
                     input int k01, input int ks);
    int ob;
    exp_t e;
    ob = 0;
    for (int i = 0; i < n; i++) begin
      TICK = 1'b1;
      IN = (alt && (i % 2 == 1)) ? 16'h0000 - a : a;
      if (tcnt == 15) begin
        e.cyc = cyc + 4;
        e.val = ob == 0 ? e0 : ob == 1 ? e1 : es;
        e.kind = ob < 2 ? k01 : ks;
        sb.push_back(e);
        ob++;
      end
      tcnt = (tcnt + 1) % 16;
      @(posedge CLK);
      #1;
      TICK = 1'b0;
      idle(gap - 1);
    end
  endtask
  initial begin
    idle(3);
    do_reset();
    // DC step 0x1000: outputs are 560/4096, 3280/4096, then 1 times the input
    run(16'h1000, 1'b0, 48, 48, 16'h0230, 16'h0CD0, 16'h1000, 0, 0);
    idle(10);
    run(16'h1000, 1'b0, 15, 4, 16'h0, 16'h0, 16'h0, 2, 2);
    TICK = 1'b1;
    IN = 16'h1000;
    @(posedge CLK);
    #1;
    TICK = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    tcnt = 0;
    chk("rst_mid_out", OUT, 16'h0000);
    chk("rst_mid_valid", {15'b0, VALID}, 16'h0000);
    idle(20);
    run(16'h1000, 1'b0, 48, 3, 16'h0230, 16'h0CD0, 16'h1000, 0, 0);
    idle(10);
    do_reset();
    run(16'h0100, 1'b0, 64, 1, 16'h0023, 16'h00CD, 16'h0100, 0, 0);
    idle(10);
    do_reset();
    run(16'h7FFF, 1'b0, 20000, 1, 16'h0, 16'h0, 16'h7FFF, 2, 0);
    run(16'h8000, 1'b0, 64, 1, 16'h0, 16'h0, 16'h8000, 2, 0);
    idle(10);
    do_reset();
`ifdef CIC_ROUND_EN
    run(16'h4000, 1'b1, 64, 2, 16'h0, 16'h0, 16'h0000, 2, 0);
`else
    run(16'h4000, 1'b1, 64, 2, 16'h0, 16'h0, 16'h0000, 2, 1);
`endif
    idle(20);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d pending outputs expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
